step_conditioner: RTL and testbench

STEP_CONDITIONER -- requirements
Module: step_conditioner

---
 rtl/step_conditioner.sv | 239 +++++++++++++++++++++++
 tb/tb_step_conditioner.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_conditioner.sv
// Step pulse conditioner: turns raw step square waves from the motion core
// into fixed-width driver pulses with direction setup time, keeps a signed
// position count per motor and exposes config/status on a small register bus.
module step_conditioner #(
    parameter int MOTORS = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [MOTORS-1:0] step_in,
    input  logic [MOTORS-1:0] dir_in,
    output logic [MOTORS-1:0] step_out,
    output logic [MOTORS-1:0] dir_out,
    input  logic [3:0]        addr,
    input  logic [31:0]       data_in,
    input  logic              read,
    input  logic              write,
    output logic [31:0]       data_out,
    output logic              ovf_irq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        GAP   = 2'd3
    } stepState_e;

    // Per-motor state
    stepState_e        state_q [MOTORS];
    stepState_e        state_d [MOTORS];
    logic [7:0]        cnt_q   [MOTORS];
    logic [7:0]        cnt_d   [MOTORS];
    logic [31:0]       pos_q   [MOTORS];
    logic [31:0]       pos_d   [MOTORS];

    logic [MOTORS-1:0] stepPrev_q;
    logic [MOTORS-1:0] pending_q, pending_d;
    logic [MOTORS-1:0] ovf_q, ovf_d;
    logic [MOTORS-1:0] dir_q, dir_d;
    logic [MOTORS-1:0] stepOut_q, stepOut_d;

    // Shared configuration
    logic [7:0]        width_q, width_d;
    logic [7:0]        setup_q, setup_d;

    // Decoded helpers
    logic [MOTORS-1:0] stepReq;
    logic [MOTORS-1:0] enterPulse;
    logic [MOTORS-1:0] ovfSet;
    logic [MOTORS-1:0] posWrite;
    logic [MOTORS-1:0] busy;
    logic [1:0]        regSel;
    logic [1:0]        motorIdx;
    logic              cfgWrite;
    logic              statWrite;
    logic [7:0]        pulseLoad;

    // The bus has no read side effects, so the read strobe is informational only.
    logic              unusedRead;
    assign unusedRead = read;

    assign regSel    = addr[3:2];
    assign motorIdx  = addr[1:0];
    assign cfgWrite  = write && (regSel == 2'd1);
    assign statWrite = write && (regSel == 2'd2);
    // A zero width still produces a one-cycle pulse and gap.
    assign pulseLoad = (width_q == 8'd0) ? 8'd0 : (width_q - 8'd1);

    assign stepReq   = step_in & ~stepPrev_q;
    assign step_out  = stepOut_q;
    assign dir_out   = dir_q;
    assign ovf_irq   = |ovf_q;

    // Position write strobes, one per existing motor; indices past MOTORS are ignored.
    always_comb begin
        posWrite = '0;
        for (int m = 0; m < MOTORS; m++) begin
            posWrite[m] = write && (regSel == 2'd0) && (int'(motorIdx) == m);
        end
    end

    // Shared width/setup register; a new value only matters at the next count load.
    always_comb begin
        width_d = width_q;
        setup_d = setup_q;
        if (cfgWrite) begin
            width_d = data_in[7:0];
            setup_d = data_in[15:8];
        end
    end

    // Per-motor pulse sequencer plus pending/overflow bookkeeping.
    always_comb begin
        pending_d  = pending_q;
        dir_d      = dir_q;
        enterPulse = '0;
        ovfSet     = '0;
        for (int m = 0; m < MOTORS; m++) begin
            state_d[m] = state_q[m];
            cnt_d[m]   = cnt_q[m];
            case (state_q[m])
                IDLE: begin
                    if (stepReq[m] || pending_q[m]) begin
                        // Consuming a pending request while a fresh one arrives re-arms pending.
                        pending_d[m] = pending_q[m] & stepReq[m];
                        if (dir_in[m] != dir_q[m]) begin
                            dir_d[m] = dir_in[m];
                            if (setup_q == 8'd0) begin
                                state_d[m]    = PULSE;
                                cnt_d[m]      = pulseLoad;
                                enterPulse[m] = 1'b1;
                            end else begin
                                state_d[m] = SETUP;
                                cnt_d[m]   = setup_q - 8'd1;
                            end
                        end else begin
                            state_d[m]    = PULSE;
                            cnt_d[m]      = pulseLoad;
                            enterPulse[m] = 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (cnt_q[m] == 8'd0) begin
                        state_d[m]    = PULSE;
                        cnt_d[m]      = pulseLoad;
                        enterPulse[m] = 1'b1;
                    end else begin
                        cnt_d[m] = cnt_q[m] - 8'd1;
                    end
                end
                PULSE: begin
                    if (cnt_q[m] == 8'd0) begin
                        state_d[m] = GAP;
                        cnt_d[m]   = pulseLoad;
                    end else begin
                        cnt_d[m] = cnt_q[m] - 8'd1;
                    end
                end
                GAP: begin
                    if (cnt_q[m] == 8'd0) begin
                        state_d[m] = IDLE;
                    end else begin
                        cnt_d[m] = cnt_q[m] - 8'd1;
                    end
                end
                default: begin
                    state_d[m] = IDLE;
                end
            endcase
            if ((state_q[m] != IDLE) && stepReq[m]) begin
                if (pending_q[m]) begin
                    ovfSet[m] = 1'b1;
                end else begin
                    pending_d[m] = 1'b1;
                end
            end
        end
    end

    // Registered step output follows the next state so the pins never glitch.
    always_comb begin
        stepOut_d = '0;
        busy      = '0;
        for (int m = 0; m < MOTORS; m++) begin
            stepOut_d[m] = (state_d[m] == PULSE);
            busy[m]      = (state_q[m] != IDLE);
        end
    end

    // Position counters and sticky overflow; bus writes beat the step update, a set beats a clear.
    always_comb begin
        ovf_d = ovfSet | (ovf_q & ~(statWrite ? data_in[MOTORS-1:0] : '0));
        for (int m = 0; m < MOTORS; m++) begin
            pos_d[m] = pos_q[m];
            if (posWrite[m]) begin
                pos_d[m] = data_in;
            end else if (enterPulse[m]) begin
                pos_d[m] = pos_q[m] + (dir_d[m] ? 32'hFFFF_FFFF : 32'd1);
            end
        end
    end

    // Combinational read mux; anything unmapped reads as zero.
    always_comb begin
        data_out = '0;
        case (regSel)
            2'd0: begin
                for (int m = 0; m < MOTORS; m++) begin
                    if (int'(motorIdx) == m) begin
                        data_out = pos_q[m];
                    end
                end
            end
            2'd1: begin
                data_out = {16'd0, setup_q, width_q};
            end
            2'd2: begin
                data_out[MOTORS-1:0]  = ovf_q;
                data_out[8 +: MOTORS] = busy;
            end
            default: begin
                data_out = '0;
            end
        endcase
    end

    // All state registers; reset drops step_out immediately without touching counts further.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int m = 0; m < MOTORS; m++) begin
                state_q[m] <= IDLE;
                cnt_q[m]   <= '0;
                pos_q[m]   <= '0;
            end
            stepPrev_q <= '0;
            pending_q  <= '0;
            ovf_q      <= '0;
            dir_q      <= '0;
            stepOut_q  <= '0;
            width_q    <= 8'd50;
            setup_q    <= 8'd25;
        end else begin
            for (int m = 0; m < MOTORS; m++) begin
                state_q[m] <= state_d[m];
                cnt_q[m]   <= cnt_d[m];
                pos_q[m]   <= pos_d[m];
            end
            stepPrev_q <= step_in;
            pending_q  <= pending_d;
            ovf_q      <= ovf_d;
            dir_q      <= dir_d;
            stepOut_q  <= stepOut_d;
            width_q    <= width_d;
            setup_q    <= setup_d;
        end
    end

endmodule

// File: tb/tb_step_conditioner.sv
// Self-checking bench for step_conditioner: register vector table, directed
// multi-cycle scenarios and a randomized run against a timeline model.
module tb_step_conditioner;

    localparam int M = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [M-1:0]  step_in;
    logic [M-1:0]  dir_in;
    logic [M-1:0]  step_out;
    logic [M-1:0]  dir_out;
    logic [3:0]    addr;
    logic [31:0]   data_in;
    logic          read;
    logic          write;
    logic [31:0]   data_out;
    logic          ovf_irq;

    int total = 0;
    int bad   = 0;

    // Measurement results for the directed scenarios
    int firstHi [M];
    int hiCnt   [M];
    int rises   [M];
    logic [M-1:0] dirAtFirst;

    // Timeline model for the randomized run
    int          mFree  [M];
    int          mStart [M];
    int          mEnd   [M];
    logic        mPend  [M];
    logic        mOvf   [M];
    logic        mDir   [M];
    logic        mPrev  [M];
    logic [31:0] mPos   [M];

    typedef struct {
        logic [3:0]  a;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] expRead;
    } busVec_t;

    busVec_t vecs [10];

    step_conditioner #(.MOTORS(M)) dut (
        .clk      (clk),
        .reset    (reset),
        .step_in  (step_in),
        .dir_in   (dir_in),
        .step_out (step_out),
        .dir_out  (dir_out),
        .addr     (addr),
        .data_in  (data_in),
        .read     (read),
        .write    (write),
        .data_out (data_out),
        .ovf_irq  (ovf_irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset   = 1'b1;
        step_in = '0;
        dir_in  = '0;
        write   = 1'b0;
        read    = 1'b0;
        addr    = '0;
        data_in = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic wr, input logic [31:0] d);
        tick();
        addr    = a;
        data_in = d;
        write   = wr;
        if (wr) begin
            tick();
            write = 1'b0;
        end
    endtask

    task automatic busRead(input logic [3:0] a, output logic [31:0] d);
        tick();
        addr = a;
        read = 1'b1;
        #1;
        d    = data_out;
        read = 1'b0;
    endtask

    // Raise step_in on the masked motors for one cycle and watch step_out for a while.
    task automatic measure(input logic [M-1:0] mask, input int cycles);
        logic [M-1:0] prevOut;
        for (int m = 0; m < M; m++) begin
            firstHi[m] = -1;
            hiCnt[m]   = 0;
            rises[m]   = 0;
        end
        prevOut = step_out;
        step_in = mask;
        for (int k = 1; k <= cycles; k++) begin
            tick();
            if (k == 1) begin
                step_in    = '0;
                dirAtFirst = dir_out;
            end
            for (int m = 0; m < M; m++) begin
                if (step_out[m]) begin
                    hiCnt[m]++;
                    if (firstHi[m] < 0) firstHi[m] = k;
                    if (!prevOut[m]) rises[m]++;
                end
            end
            prevOut = step_out;
        end
    endtask

    // Drive a list of request cycles on motor 0 and count emitted pulses.
    task automatic stepPattern(input int c0, input int c1, input int c2, input int cycles, output int nPulses);
        logic prev;
        nPulses = 0;
        prev    = step_out[0];
        for (int k = 0; k < cycles; k++) begin
            step_in[0] = (k == c0) || (k == c1) || (k == c2);
            tick();
            if (step_out[0] && !prev) nPulses++;
            prev = step_out[0];
        end
        step_in = '0;
    endtask

    task automatic randomRun(input logic [7:0] w, input logic [7:0] s, input int nCyc);
        int          effW;
        int          sc;
        logic [M-1:0] expStep, expDir;
        logic        anyOvf;
        logic        req;
        logic [31:0] rd;
        logic [31:0] expStat;
        doReset();
        applyStimulus(4'h4, 1'b1, {16'd0, s, w});
        effW = (w == 8'd0) ? 1 : int'(w);
        for (int m = 0; m < M; m++) begin
            mFree[m] = 0; mStart[m] = -10; mEnd[m] = -10;
            mPend[m] = 0; mOvf[m] = 0; mDir[m] = 0; mPrev[m] = 0; mPos[m] = '0;
        end
        for (int cyc = 0; cyc < nCyc + 60; cyc++) begin
            anyOvf = 1'b0;
            for (int m = 0; m < M; m++) begin
                expStep[m] = (cyc >= mStart[m]) && (cyc <= mEnd[m]);
                expDir[m]  = mDir[m];
                anyOvf     = anyOvf | mOvf[m];
            end
            checkOutput($sformatf("rand step_out c%0d", cyc), 32'(step_out), 32'(expStep));
            checkOutput($sformatf("rand dir_out c%0d", cyc), 32'(dir_out), 32'(expDir));
            checkOutput($sformatf("rand ovf_irq c%0d", cyc), 32'(ovf_irq), 32'(anyOvf));
            for (int m = 0; m < M; m++) begin
                step_in[m] = (cyc < nCyc) && ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 9) == 0) dir_in[m] = ~dir_in[m];
                req      = step_in[m] & ~mPrev[m];
                mPrev[m] = step_in[m];
                if (cyc >= mFree[m]) begin
                    if (mPend[m] || req) begin
                        mPend[m] = mPend[m] & req;
                        sc = 0;
                        if (dir_in[m] != mDir[m]) begin
                            mDir[m] = dir_in[m];
                            sc = int'(s);
                        end
                        mStart[m] = cyc + 1 + sc;
                        mEnd[m]   = cyc + sc + effW;
                        mFree[m]  = cyc + sc + 2 * effW + 1;
                        mPos[m]   = mPos[m] + (mDir[m] ? 32'hFFFF_FFFF : 32'd1);
                    end
                end else if (req) begin
                    if (mPend[m]) mOvf[m] = 1'b1;
                    else          mPend[m] = 1'b1;
                end
            end
            tick();
        end
        expStat = '0;
        for (int m = 0; m < M; m++) begin
            busRead(4'(m), rd);
            checkOutput($sformatf("rand POS%0d", m), rd, mPos[m]);
            expStat[m] = mOvf[m];
        end
        busRead(4'h8, rd);
        checkOutput("rand STAT", rd, expStat);
    endtask

    initial begin
        logic [31:0] rd;
        int          n;

        vecs[0] = '{4'h4, 1'b0, 32'h0,          32'h0000_1932};
        vecs[1] = '{4'h0, 1'b0, 32'h0,          32'h0};
        vecs[2] = '{4'h8, 1'b0, 32'h0,          32'h0};
        vecs[3] = '{4'hC, 1'b0, 32'h0,          32'h0};
        vecs[4] = '{4'h3, 1'b0, 32'h0,          32'h0};
        vecs[5] = '{4'h1, 1'b1, 32'h1234_5678,  32'h1234_5678};
        vecs[6] = '{4'h0, 1'b0, 32'h0,          32'h0};
        vecs[7] = '{4'h4, 1'b1, 32'hABCD_0A03,  32'h0000_0A03};
        vecs[8] = '{4'h3, 1'b1, 32'hFFFF_FFFF,  32'h0};
        vecs[9] = '{4'h8, 1'b1, 32'h0000_00FF,  32'h0};

        // Register map after reset
        doReset();
        checkOutput("reset step_out", 32'(step_out), 32'h0);
        checkOutput("reset dir_out", 32'(dir_out), 32'h0);
        checkOutput("reset ovf_irq", 32'(ovf_irq), 32'h0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].wr, vecs[i].wdata);
            busRead(vecs[i].a, rd);
            checkOutput($sformatf("vec%0d", i), rd, vecs[i].expRead);
        end

        // Single positive step, width 4, setup 2, no direction change
        doReset();
        applyStimulus(4'h4, 1'b1, 32'h0000_0204);
        measure(3'b001, 12);
        checkOutput("pos step first high", 32'(firstHi[0]), 32'd1);
        checkOutput("pos step high cycles", 32'(hiCnt[0]), 32'd4);
        checkOutput("pos step pulses", 32'(rises[0]), 32'd1);
        checkOutput("pos step dir_out", 32'(dir_out), 32'h0);
        busRead(4'h0, rd);
        checkOutput("pos step POS0", rd, 32'd1);

        // Direction change: setup delay then pulse, counter goes negative
        applyStimulus(4'h0, 1'b1, 32'h0);
        dir_in[0] = 1'b1;
        measure(3'b001, 14);
        checkOutput("neg step dir early", 32'(dirAtFirst[0]), 32'h1);
        checkOutput("neg step first high", 32'(firstHi[0]), 32'd3);
        checkOutput("neg step high cycles", 32'(hiCnt[0]), 32'd4);
        busRead(4'h0, rd);
        checkOutput("neg step POS0", rd, 32'hFFFF_FFFF);

        // Pend then overflow, then clear through STAT
        doReset();
        applyStimulus(4'h4, 1'b1, 32'h0000_0204);
        stepPattern(0, 3, 6, 30, n);
        checkOutput("ovf pulses", 32'(n), 32'd2);
        checkOutput("ovf irq set", 32'(ovf_irq), 32'h1);
        busRead(4'h8, rd);
        checkOutput("ovf STAT", rd, 32'h0000_0001);
        applyStimulus(4'h8, 1'b1, 32'h1);
        busRead(4'h8, rd);
        checkOutput("ovf STAT cleared", rd, 32'h0);
        checkOutput("ovf irq cleared", 32'(ovf_irq), 32'h0);

        // Request on the IDLE consume cycle re-pends without overflow
        stepPattern(0, 3, 9, 40, n);
        checkOutput("consume pulses", 32'(n), 32'd3);
        checkOutput("consume no ovf", 32'(ovf_irq), 32'h0);

        // Signed wrap from max positive
        doReset();
        applyStimulus(4'h4, 1'b1, 32'h0000_0204);
        applyStimulus(4'h0, 1'b1, 32'h7FFF_FFFF);
        measure(3'b001, 12);
        busRead(4'h0, rd);
        checkOutput("wrap POS0", rd, 32'h8000_0000);

        // Zero width/setup: 1-cycle pulses, independent counters
        doReset();
        applyStimulus(4'h4, 1'b1, 32'h0);
        measure(3'b111, 4);
        for (int m = 0; m < M; m++) begin
            checkOutput($sformatf("w0 m%0d first high", m), 32'(firstHi[m]), 32'd1);
            checkOutput($sformatf("w0 m%0d high cycles", m), 32'(hiCnt[m]), 32'd1);
        end
        measure(3'b011, 4);
        measure(3'b001, 4);
        for (int m = 0; m < M; m++) begin
            busRead(4'(m), rd);
            checkOutput($sformatf("w0 POS%0d", m), rd, 32'(3 - m));
        end

        // Reset in the middle of a pulse
        doReset();
        applyStimulus(4'h4, 1'b1, 32'h0000_0204);
        step_in[0] = 1'b1;
        tick();
        step_in = '0;
        tick();
        checkOutput("midreset pulse active", 32'(step_out), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset step_out", 32'(step_out), 32'h0);
        tick();
        reset = 1'b0;
        busRead(4'h0, rd);
        checkOutput("midreset POS0", rd, 32'h0);
        busRead(4'h4, rd);
        checkOutput("midreset CFG", rd, 32'h0000_1932);
        busRead(4'h8, rd);
        checkOutput("midreset STAT", rd, 32'h0);
        checkOutput("midreset dir_out", 32'(dir_out), 32'h0);

        // Randomized runs against the timeline model
        randomRun(8'd3, 8'd2, 1500);
        randomRun(8'd0, 8'd0, 800);
        randomRun(8'd5, 8'd0, 800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
